bram_fifo_ctrl: RTL

- Ready/valid FIFO controller wrapped around the byte-enabled 1R1W BRAM block.
- Drives the BRAM write side (wr_addr, per-byte wr_en, din) from an input stream.
- Drives the BRAM read side (rd_addr) and turns the registered dout into an output stream through a 2-entry skid buffer.
- Sits between a producer (e.g. DMA or packet parser) and a consumer, with the BRAM instantiated beside it in the parent.

---
 rtl/bram_fifo_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bram_fifo_ctrl.sv
`timescale 1ns/1ps
// bram_fifo_ctrl: ready/valid FIFO controller for a byte-enabled 1R1W BRAM
// with a registered read port. The BRAM sits beside this block in the parent.
//
// Ports:
//   clock, reset_n                    single clock, async active-low reset
//   in_valid/in_ready/in_data         input stream
//   out_valid/out_ready/out_data      output stream (2-entry skid buffer)
//   bram_wr_addr/bram_wr_en/bram_din  BRAM write side (full-word writes only)
//   bram_rd_addr/bram_dout            BRAM read side (dout lags rd_addr by 1)
//   count/full/empty                  occupancy status
//   flush                             sync clear, only with BRAM_FIFO_FLUSH_EN
//
// Optional feature macro: BRAM_FIFO_FLUSH_EN (adds the flush input).
module bram_fifo_ctrl #(
    parameter int unsigned BRAM_ADDR_WIDTH = 6,
    parameter int unsigned BRAM_DATA_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset_n,
`ifdef BRAM_FIFO_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [BRAM_DATA_WIDTH-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BRAM_DATA_WIDTH-1:0]   out_data,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_rd_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_wr_addr,
    output logic [BRAM_DATA_WIDTH/8-1:0] bram_wr_en,
    output logic [BRAM_DATA_WIDTH-1:0]   bram_din,
    input  logic [BRAM_DATA_WIDTH-1:0]   bram_dout,
    output logic [BRAM_ADDR_WIDTH+1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW    = BRAM_ADDR_WIDTH;
    localparam int unsigned DW    = BRAM_DATA_WIDTH;
    localparam int unsigned BW    = DW / 8;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned CW    = AW + 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_pending_q, rd_pending_d;
    logic [DW-1:0] skid0_q, skid0_d;
    logic [DW-1:0] skid1_q, skid1_d;
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          out_valid_q, out_valid_d;

    logic          flush_c;
    logic          accept_c;
    logic          pop_c;
    logic          issue_c;
    logic [PW-1:0] occ_c;
    logic [1:0]    inflight_c;

`ifdef BRAM_FIFO_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Handshakes and read-issue decision, all from registered state.
    always_comb begin
        accept_c   = in_valid && !full_q && !flush_c;
        pop_c      = out_valid_q && out_ready;
        occ_c      = wr_ptr_q - rd_ptr_q;
        // Words that will occupy the skid buffer once the pending read lands.
        inflight_c = skid_cnt_q + 2'(rd_pending_q) - 2'(pop_c);
        issue_c    = (occ_c != '0) && (inflight_c < 2'd2);
    end

    // Next-state: pointers, skid buffer, status.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_pending_d = issue_c;
        skid0_d      = skid0_q;
        skid1_d      = skid1_q;
        skid_cnt_d   = skid_cnt_q;
        count_d      = count_q + CW'(accept_c) - CW'(pop_c);

        if (accept_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (issue_c)  rd_ptr_d = rd_ptr_q + PW'(1);

        // A pending read delivers its word this cycle; headroom check above
        // guarantees the buffer never overflows.
        case ({rd_pending_q, pop_c})
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid0_d = bram_dout;
                else                    skid1_d = bram_dout;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                skid0_d    = skid1_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid0_d = bram_dout;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = bram_dout;
                end
            end
            default: ;
        endcase

        if (flush_c) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            rd_pending_d = 1'b0;
            skid_cnt_d   = 2'd0;
            count_d      = '0;
        end

        full_d      = ((wr_ptr_d - rd_ptr_d) == PW'(DEPTH));
        empty_d     = (count_d == '0);
        out_valid_d = (skid_cnt_d != 2'd0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_pending_q <= 1'b0;
            skid0_q      <= '0;
            skid1_q      <= '0;
            skid_cnt_q   <= 2'd0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_pending_q <= rd_pending_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
            skid_cnt_q   <= skid_cnt_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // BRAM write strobes must be combinational so the word lands this edge.
    assign in_ready     = !full_q && !flush_c;
    assign bram_wr_en   = accept_c ? {BW{1'b1}} : {BW{1'b0}};
    assign bram_wr_addr = wr_ptr_q[AW-1:0];
    assign bram_din     = in_data;
    assign bram_rd_addr = rd_ptr_q[AW-1:0];
    assign out_valid    = out_valid_q;
    assign out_data     = skid0_q;
    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;

endmodule
